uart_rx: RTL and testbench

Asynchronous serial receiver for 8N1 frames: 1 start bit, 8 data bits LSB first, 1 stop bit, no parity. It sits beside the UART transmitter on the processor's serial port and shares its CLK_FREQ and BAUD_RATE parameters, so the two ends agree on bit timing. The line input is synchronised, the start bit is qualified at mid-bit, and every data and stop bit is sampled at its nominal centre. Each completed byte is presented as a one-cycle valid pulse, or as a framing-error pulse if the stop bit is bad.

---
 rtl/uart_rx.sv | 149 ++++++++++++++
 tb/tb_uart_rx.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/uart_rx.sv
// 8N1 serial receiver: two-flop line synchroniser, mid-bit start qualification,
// centre sampling of data and stop bits, one-cycle valid / framing-error pulses.
module uart_rx #(
  parameter int CLK_FREQ  = 80_000_000,
  parameter int BAUD_RATE = 115200
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_rx,
  output logic [7:0] o_data,
  output logic       o_rx_valid,
  output logic       o_frame_err,
  output logic       o_rx_busy,
  output logic [1:0] o_state_debug
);

  localparam int BIT_TIME  = (CLK_FREQ + BAUD_RATE / 2) / BAUD_RATE;
  localparam int HALF_TIME = BIT_TIME / 2;
  localparam int CNT_W     = $clog2(BIT_TIME) + 1;

  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(BIT_TIME - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_TIME - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  logic             rx_meta_p0;
  logic             rx_s;

  state_t           state_q,  state_d;
  logic [CNT_W-1:0] cnt_q,    cnt_d;
  logic [2:0]       idx_q,    idx_d;
  logic [7:0]       shift_q,  shift_d;
  logic [7:0]       data_q,   data_d;
  logic             valid_q,  valid_d;
  logic             ferr_q,   ferr_d;
  logic             armed_q,  armed_d;

  // Line synchroniser: only rx_s is visible to the FSM
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      rx_meta_p0 <= 1'b1;
      rx_s       <= 1'b1;
    end else begin
      rx_meta_p0 <= i_rx;
      rx_s       <= rx_meta_p0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
      armed_q <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
      armed_q <= armed_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    data_d  = data_q;
    valid_d = 1'b0;
    ferr_d  = 1'b0;
    armed_d = armed_q;

    case (state_q)
      IDLE: begin
        cnt_d = '0;
        idx_d = '0;
        // A low line only starts a frame once it has been seen high, so a
        // held-low break after a framing error is not decoded as 0x00 frames
        if (rx_s) begin
          armed_d = 1'b1;
        end else if (armed_q) begin
          state_d = START;
        end
      end

      START: begin
        if (cnt_q == HALF_LAST) begin
          cnt_d   = '0;
          state_d = rx_s ? IDLE : DATA;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      DATA: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d          = '0;
          shift_d[idx_q] = rx_s;
          if (idx_q == 3'd7) begin
            idx_d   = '0;
            state_d = STOP;
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      STOP: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d   = '0;
          state_d = IDLE;
          if (rx_s) begin
            data_d  = shift_q;
            valid_d = 1'b1;
          end else begin
            ferr_d  = 1'b1;
            armed_d = 1'b0;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  assign o_data        = data_q;
  assign o_rx_valid    = valid_q;
  assign o_frame_err   = ferr_q;
  assign o_rx_busy     = (state_q != IDLE);
  assign o_state_debug = state_q;

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx: a bit-banged transmitter queues expected bytes,
// an independent negedge monitor pops and compares on every output pulse.
module tb_uart_rx;

  localparam int CLK_FREQ  = 1_600_000;
  localparam int BAUD_RATE = 100_000;

  logic       clk;
  logic       rst;
  logic       i_rx;
  logic [7:0] o_data;
  logic       o_rx_valid;
  logic       o_frame_err;
  logic       o_rx_busy;
  logic [1:0] o_state_debug;

  uart_rx #(
    .CLK_FREQ (CLK_FREQ),
    .BAUD_RATE(BAUD_RATE)
  ) dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_rx         (i_rx),
    .o_data       (o_data),
    .o_rx_valid   (o_rx_valid),
    .o_frame_err  (o_frame_err),
    .o_rx_busy    (o_rx_busy),
    .o_state_debug(o_state_debug)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk  = 0;
  int n_fail = 0;

  typedef struct {
    int         kind;   // 0 = good byte, 1 = framing error
    logic [7:0] data;
    int         cyc;    // expected monitor cycle, -1 = untimed
  } exp_t;

  exp_t       sbq[$];
  logic [7:0] last_good = 8'h00;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  // Drives one frame starting at a negedge; p100 is the bit period in 1/100 cycles.
  // Latency: line driven before edge k=cyc+1, pulse visible at negedge with cyc=k+154.
  task automatic send(input logic [7:0] b, input logic stop_bit, input int p100,
                      input bit timed);
    logic [9:0] fr;
    exp_t       e;
    int         t;
    int         end_t;
    fr = {stop_bit, b, 1'b0};
    @(negedge clk);
    e.kind = stop_bit ? 0 : 1;
    e.data = stop_bit ? b : last_good;
    e.cyc  = timed ? cyc + 155 : -1;
    if (stop_bit) last_good = b;
    sbq.push_back(e);
    t = 0;
    for (int i = 0; i < 10; i++) begin
      i_rx  = fr[i];
      end_t = ((i + 1) * p100 + 50) / 100;
      while (t < end_t) begin
        @(negedge clk);
        t++;
      end
    end
  endtask

  // Monitor: pulses against scoreboard, state sequence legality
  logic [1:0] prev_state = 2'd0;
  always @(negedge clk) begin
    exp_t       e;
    logic [1:0] nxt;
    if (o_state_debug != prev_state) begin
      nxt = prev_state + 2'd1;
      chk("state_seq", 32'(o_state_debug == nxt || o_state_debug == 2'd0), 32'd1);
      chk("busy_vs_state", 32'(o_rx_busy), 32'(o_state_debug != 2'd0));
      prev_state = o_state_debug;
    end
    if (o_rx_valid || o_frame_err) begin
      chk("pulse_exclusive", 32'(o_rx_valid && o_frame_err), 32'd0);
      if (sbq.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_pulse: got valid=%0d ferr=%0d data=0x%0h, expected none",
                 o_rx_valid, o_frame_err, o_data);
      end else begin
        e = sbq.pop_front();
        chk("pulse_kind", 32'(o_frame_err), 32'(e.kind));
        chk("rx_data", 32'(o_data), 32'(e.data));
        if (e.cyc >= 0) chk("pulse_latency", 32'(cyc), 32'(e.cyc));
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int bc;
    rst  = 1'b1;
    i_rx = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_data",  32'(o_data),        32'h00);
    chk("rst_valid", 32'(o_rx_valid),    32'd0);
    chk("rst_ferr",  32'(o_frame_err),   32'd0);
    chk("rst_busy",  32'(o_rx_busy),     32'd0);
    chk("rst_state", 32'(o_state_debug), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_state", 32'(o_state_debug), 32'd0);

    // Partial 0x3C frame aborted by reset during DATA
    i_rx = 1'b0;
    repeat (16) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      i_rx = bit'((8'h3C >> i) & 8'h01);
      repeat (16) @(negedge clk);
    end
    chk("pre_abort_state", 32'(o_state_debug), 32'd2);
    rst = 1'b1;
    @(negedge clk);
    chk("abort_state", 32'(o_state_debug), 32'd0);
    chk("abort_busy",  32'(o_rx_busy),     32'd0);
    i_rx = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    repeat (200) @(negedge clk);
    chk("abort_data",  32'(o_data),        32'h00);
    chk("abort_idle",  32'(o_state_debug), 32'd0);

    // Back-to-back loopback frames
    send(8'hA5, 1'b1, 1600, 1'b1);
    send(8'h00, 1'b1, 1600, 1'b1);
    send(8'hFF, 1'b1, 1600, 1'b1);
    repeat (30) @(negedge clk);

    // Four-cycle glitch: START lasts HALF_TIME cycles, then back to IDLE
    bc   = 0;
    i_rx = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (i == 3) i_rx = 1'b1;
      if (o_rx_busy) bc++;
    end
    chk("glitch_busy_cycles", 32'(bc), 32'd8);
    chk("glitch_state", 32'(o_state_debug), 32'd0);
    chk("glitch_data",  32'(o_data),        32'hFF);

    // Framing error followed by a held-low break, then recovery
    send(8'h55, 1'b0, 1600, 1'b1);
    repeat (480) @(negedge clk);
    chk("break_idle", 32'(o_state_debug), 32'd0);
    i_rx = 1'b1;
    repeat (20) @(negedge clk);
    send(8'h81, 1'b1, 1600, 1'b1);
    repeat (20) @(negedge clk);

    // Bit-rate skew of +3% and -3%
    send(8'h6E, 1'b1, 1648, 1'b0);
    repeat (20) @(negedge clk);
    send(8'h6E, 1'b1, 1552, 1'b0);

    for (int i = 0; i < 400 && sbq.size() != 0; i++) @(negedge clk);
    chk("scoreboard_drained", 32'(sbq.size()), 32'd0);
    repeat (20) @(negedge clk);
    chk("final_data",  32'(o_data),        32'h6E);
    chk("final_state", 32'(o_state_debug), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
